// File: rtl/frame_uart_tx.sv
// frame_uart_tx
//   Sends a 512-bit frame as one 66-byte UART packet (8N1, LSB first):
//   HEADER, frame bytes 0..63 in ascending order, then the mod-256 sum of
//   the 64 frame bytes. The frame is captured when a request is accepted,
//   and the bytes go out back-to-back with no idle gap between them.
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   frame_cube_flat frame to send; byte k = bits [8k+7:8k]
//   send_req        transmit request; sampled only while idle
//   tx              UART line (registered, idles high)
//   busy            high while a packet is in flight
//   done            one-cycle pulse in the cycle busy falls
module frame_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] frame_cube_flat,
  input  logic         send_req,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q;
  logic [CW-1:0]  clk_cnt_q;
  logic [7:0]     bit_cnt_q;
  logic [6:0]     byte_idx_q;
  logic [511:0]   snap_q;
  logic [7:0]     shift_q;
  logic [7:0]     csum_q;
  logic           tx_q, busy_q, done_q;

  logic           bit_end;
  logic [7:0]     next_frame_byte;
  logic [7:0]     next_byte_d;

  assign bit_end = (clk_cnt_q == CNT_MAX);

  // Byte that follows the one currently in flight. Packet index i (1..64)
  // carries frame byte i-1, so the byte after index idx is frame byte idx;
  // after index 64 comes the checksum.
  always_comb begin
    next_frame_byte = snap_q[{byte_idx_q[5:0], 3'b000} +: 8];
    next_byte_d     = (byte_idx_q == 7'd64) ? csum_q : next_frame_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      snap_q     <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE)
        clk_cnt_q <= bit_end ? '0 : clk_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          if (send_req) begin
            state_q    <= START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            snap_q     <= frame_cube_flat;
            shift_q    <= HEADER;
            byte_idx_q <= '0;
            bit_cnt_q  <= '0;
            csum_q     <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == 8'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 8'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (byte_idx_q == 7'd65) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= START;
              tx_q       <= 1'b0;
              byte_idx_q <= byte_idx_q + 7'd1;
              shift_q    <= next_byte_d;
              // Accumulate each frame byte as it is loaded; the sum is
              // complete by the time index 65 (checksum) is loaded.
              if (byte_idx_q < 7'd64)
                csum_q <= csum_q + next_frame_byte;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/frame_uart_tx.md
FRAME_UART_TX -- requirements
Module: frame_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 The block SHALL have parameter HEADER, default 8'hA5, meaning the first byte of every packet.
REQ-003 The block SHALL have port clk, input, 1 bit, the 100 MHz system clock; all logic runs on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port frame_cube_flat, input, 512 bits, the frame to send; byte k is bits [8k+7:8k], k=0..63.
REQ-006 The block SHALL have port send_req, input, 1 bit, a request to transmit the current frame.
REQ-007 The block SHALL have port tx, output, 1 bit, the UART line, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a packet is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse when a packet completes.

Function
REQ-010 The packet SHALL be 66 bytes: HEADER, frame bytes 0..63 in ascending k, then a checksum byte.
REQ-011 The checksum SHALL be the sum of the 64 frame bytes modulo 256; HEADER is excluded.
REQ-012 Each byte SHALL be framed 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-013 Each bit SHALL last exactly CLKS_PER_BIT cycles, and bytes SHALL go back-to-back with no idle gap, so a packet lasts 660*CLKS_PER_BIT cycles.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, with an 8-bit bit counter and a 7-bit byte index 0..65.
REQ-015 IDLE -> START SHALL happen when send_req=1 and busy=0.
REQ-016 START -> DATA SHALL happen after 1 bit time.
REQ-017 DATA -> STOP SHALL happen after 8 bit times.
REQ-018 On STOP end with byte index < 65, the FSM SHALL increment the index and go STOP -> START.
REQ-019 On STOP end with byte index = 65, the FSM SHALL go STOP -> IDLE.
REQ-020 On acceptance, frame_cube_flat SHALL be snapshotted into an internal 512-bit register, so input changes during transmission do not affect the packet.
REQ-021 The checksum SHALL be accumulated from the snapshot as bytes are sent, or precomputed from it, and SHALL be ready before byte 65 starts.
REQ-022 Latency: tx SHALL go low (start bit) and busy SHALL go high in the cycle after the send_req acceptance edge.
REQ-023 send_req while busy=1 SHALL be ignored and not queued.
REQ-024 send_req held high continuously SHALL start a new packet in the cycle after busy falls.
REQ-025 done SHALL pulse for 1 cycle in the cycle that busy falls, i.e. the first cycle after the last stop bit's CLKS_PER_BIT cycles.
REQ-026 tx SHALL be registered and glitch-free, and tx=1 in IDLE.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL set tx=1, busy=0, done=0, state IDLE, and clear all counters, the checksum and the snapshot.
REQ-028 Reset mid-packet SHALL abort at once, with tx high in the next cycle and no done pulse.
REQ-029 After rst is released, the block SHALL accept send_req on the first following edge.

Verification (CLKS_PER_BIT=4 in simulation; one packet = 2640 cycles)
REQ-030 Bench SHALL check: all-zero frame, single send_req pulse -> bytes A5, 64x00, checksum 00; done exactly once, 2640 cycles after the tx falling edge.
REQ-031 Bench SHALL check: frame byte k = k -> bytes A5, 00..3F, checksum E0 (2016 mod 256).
REQ-032 Bench SHALL check: frame all FF -> checksum C0; a frame changed to all 00 one cycle after acceptance still sends 64xFF.
REQ-033 Bench SHALL check: send_req pulsed 3 times during a packet -> exactly one packet and one done pulse.
REQ-034 Bench SHALL check: rst asserted at cycle 1000 of a packet -> tx=1 and busy=0 the next cycle, no done pulse; a fresh send_req then yields a complete, correct packet.
REQ-035 Bench SHALL check: send_req tied high -> consecutive packets, each start bit in the cycle after done, with a UART monitor verifying every bit width equals 4 cycles.
